// File: rtl/sigma_delta_pkg.sv
// Shared types and sizing helpers for the sigma-delta interpolator.
// The state enum is also carried on the interface so the FSM stays observable.
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } interp_state_t;

    function automatic logic [63:0] midscale(input int bitlen);
        return 64'd1 << (bitlen - 1);
    endfunction

    // Two headroom bits keep the accumulator sign clear of the sample range.
    function automatic int acc_width(input int bitlen, input int osr_log2);
        return bitlen + osr_log2 + 2;
    endfunction

endpackage

// File: rtl/sigma_delta_interp_if.sv
// Sample-in / DAC-out bundle between an upstream source and sigma_delta_interp.
// The slave side also publishes the interpolator FSM state for observation.
interface sigma_delta_interp_if #(
    parameter int DAC_BITLEN = 24
) ();
    import sigma_delta_pkg::*;

    // A sample transfers on each rising edge where in_valid && in_ready; in_data is held
    // stable while in_valid waits for in_ready. out_valid is a one-cycle strobe with no
    // back-pressure, and underrun is a one-cycle strobe on an empty segment boundary.
    logic [DAC_BITLEN-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DAC_BITLEN-1:0] out_data;
    logic                  out_valid;
    logic                  underrun;
    interp_state_t         state;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid, underrun, state
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid, underrun, state
    );

endinterface

// File: rtl/sigma_delta_tick_gen.sv
// Free-running step timer: tick every STEP_CLKS clocks, boundary on the last
// tick of each 2^OSR_LOG2-step segment.
module sigma_delta_tick_gen #(
    parameter int STEP_CLKS = 16,
    parameter int OSR_LOG2  = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o,
    output logic boundary_o
);

    localparam int CW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam int SW = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(STEP_CLKS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'((1 << OSR_LOG2) - 1);

    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;

    always_comb begin
        tick_o     = (clk_cnt_q == CLK_LAST);
        boundary_o = tick_o && (step_cnt_q == STEP_LAST);
        clk_cnt_d  = tick_o ? '0 : clk_cnt_q + CW'(1);
        step_cnt_d = step_cnt_q;
        if (tick_o) begin
            step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/sigma_delta_interp.sv
// Linear interpolator feeding sigma_delta_dac: ramps between consecutive input
// samples in 2^OSR_LOG2 steps, starting from midscale and holding on underrun.
module sigma_delta_interp
    import sigma_delta_pkg::*;
#(
    parameter int DAC_BITLEN = 24,
    parameter int OSR_LOG2   = 4,
    parameter int STEP_CLKS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sigma_delta_interp_if.slave  bus
);

    localparam int DW = DAC_BITLEN;
    localparam int AW = acc_width(DAC_BITLEN, OSR_LOG2);
    localparam logic [DW-1:0] MID = DW'(midscale(DAC_BITLEN));

    function automatic logic signed [AW-1:0] to_acc(input logic [DW-1:0] v);
        return $signed({{(AW-DW){1'b0}}, v} << OSR_LOG2);
    endfunction

    logic tick, boundary, accept;

    interp_state_t state_q, state_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [DW-1:0]        hold_data_q, hold_data_d;
    logic                 in_ready_q, in_ready_d;
    logic [DW-1:0]        prev_q, prev_d;
    logic [DW-1:0]        q_q, q_d;
    logic signed [DW:0]   delta_q, delta_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 underrun_q, underrun_d;

    logic [DW-1:0] seg_base;
    logic          load_seg;
    logic          flag_underrun;

    sigma_delta_tick_gen #(
        .STEP_CLKS (STEP_CLKS),
        .OSR_LOG2  (OSR_LOG2)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .tick_o     (tick),
        .boundary_o (boundary)
    );

    assign accept = bus.in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            if (hold_valid_q)           state_d = RUN;
            else if (state_q != IDLE)   state_d = HOLD;
        end
    end

    // Every boundary restarts from the value the output sits at: MID, the old target, or prev.
    always_comb begin
        load_seg      = 1'b0;
        flag_underrun = 1'b0;
        case (state_q)
            IDLE:    seg_base = MID;
            RUN:     seg_base = q_q;
            HOLD:    seg_base = prev_q;
            default: seg_base = MID;
        endcase
        if (boundary) begin
            load_seg      = hold_valid_q;
            flag_underrun = !hold_valid_q && (state_q != IDLE);
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        prev_d       = prev_q;
        q_d          = q_q;
        delta_d      = delta_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;

        if (load_seg) hold_valid_d = 1'b0;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.in_data;
        end

        // The boundary snaps acc to the exact endpoint so rounding never accumulates.
        if (boundary) begin
            prev_d = seg_base;
            acc_d  = to_acc(seg_base);
            if (load_seg) begin
                q_d     = hold_data_q;
                delta_d = $signed({1'b0, hold_data_q}) - $signed({1'b0, seg_base});
            end else begin
                delta_d = '0;
            end
        end else if (tick) begin
            acc_d = acc_q + {{(AW-DW-1){delta_q[DW]}}, delta_q};
        end

        if (tick) out_data_d = acc_d[DW+OSR_LOG2-1:OSR_LOG2];

        in_ready_d  = !hold_valid_d;
        out_valid_d = tick;
        underrun_d  = flag_underrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            in_ready_q   <= 1'b0;
            prev_q       <= MID;
            q_q          <= MID;
            delta_q      <= '0;
            acc_q        <= to_acc(MID);
            out_data_q   <= MID;
            out_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            in_ready_q   <= in_ready_d;
            prev_q       <= prev_d;
            q_q          <= q_d;
            delta_q      <= delta_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.underrun  = underrun_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_sigma_delta_interp.sv
// Self-checking bench for sigma_delta_interp: directed scenarios plus random
// samples, compared against a segment-level interpolation model.
module tb_sigma_delta_interp;

    localparam int DW = 24;
    localparam int OSR = 4;
    localparam int SC = 16;
    localparam int NSTEP = 1 << OSR;
    localparam longint MID = 64'h800000;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN = 1;
    localparam int MODE_HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sigma_delta_interp_if #(.DAC_BITLEN(DW)) bus ();

    sigma_delta_interp #(
        .DAC_BITLEN (DW),
        .OSR_LOG2   (OSR),
        .STEP_CLKS  (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: output of segment step k is P + floor((Q-P)*k/N), with mode flags per boundary.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_hold[$];
    int     m_n, m_mode, m_s;
    bit     m_ready, m_valid, m_under, m_tick, m_bnd;
    longint m_p, m_q, m_out, m_base;

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0; m_mode = MODE_IDLE; m_hold.delete(); exp_q.delete();
            m_ready = 0; m_valid = 0; m_under = 0;
            m_p = MID; m_q = MID; m_out = MID;
        end else begin
            m_tick = (m_n % SC) == SC - 1;
            m_s = (m_n / SC) % NSTEP;
            m_bnd = m_tick && (m_s == NSTEP - 1);
            m_valid = m_tick;
            m_under = 0;
            if (m_tick) begin
                if (m_mode == MODE_RUN) m_out = m_p + floor_div((m_q - m_p) * (m_s + 1), NSTEP);
                else m_out = m_p;
                exp_q.push_back(m_out[DW-1:0]);
            end
            if (m_bnd) begin
                m_base = (m_mode == MODE_RUN) ? m_q : m_p;
                m_p = m_base;
                if (m_hold.size() != 0) begin
                    m_q = longint'(m_hold.pop_front());
                    m_mode = MODE_RUN;
                end else if (m_mode != MODE_IDLE) begin
                    m_mode = MODE_HOLD;
                    m_under = 1;
                end
            end
            if (bus.in_valid && m_ready) m_hold.push_back(bus.in_data);
            m_ready = (m_hold.size() == 0);
            m_n++;
        end
    end

    logic [DW-1:0] log_q[$];
    int under_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("in_ready", bus.in_ready, m_ready);
            check_eq("out_valid", bus.out_valid, m_valid);
            check_eq("underrun", bus.underrun, m_under);
            check_eq("out_level", bus.out_data, m_out[DW-1:0]);
            if (bus.out_valid) begin
                check_eq("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("out_data", bus.out_data, exp_q.pop_front());
                log_q.push_back(bus.out_data);
            end
            if (bus.underrun) under_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int budget;
        bit done;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        done = 0;
        budget = 0;
        while (!done && budget < 1000) begin
            done = bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        check_eq("send_accepted", done, 1);
    endtask

    task automatic wait_log(input int n, input string tag);
        int b;
        b = 0;
        while (log_q.size() < n && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check_eq(tag, log_q.size() >= n, 1);
    endtask

    function automatic logic [DW-1:0] get_log(input int i);
        if (i >= 0 && i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    function automatic int first_not(input logic [DW-1:0] v);
        for (int i = 0; i < log_q.size(); i++) if (log_q[i] != v) return i;
        return log_q.size();
    endfunction

    initial begin
        #5ms;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, rdy, acc_n;
        int acc_cyc[$];
        int floor7[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 5, 5, 6, 6, 7};
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        // Reset state and idle output
        wait_cycles(3);
        chk_en = 1'b1;
        check_eq("rst_out_data", bus.out_data, MID);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        wait_cycles(1);
        check_eq("ready_after_rst", bus.in_ready, 1);
        log_q.delete();
        under_cnt = 0;
        wait_cycles(600);
        check_eq("t1_underruns", under_cnt, 0);
        check_eq("t1_tick_count", log_q.size(), 37);
        foreach (log_q[i]) check_eq("t1_idle_mid", log_q[i], MID);

        // Ramp from midscale by +1 per tick
        send(24'h800010);
        log_q.delete();
        wait_cycles(2 * 256 + 20);
        idx = first_not(MID[DW-1:0]);
        for (int j = 0; j < 16; j++) check_eq("t2_ramp", get_log(idx + j), MID + j + 1);

        // Floor stepping up, then descending segment
        do_reset();
        log_q.delete();
        send(24'h800007);
        send(24'h7FFFF0);
        wait_log(48, "t3_log_timeout");
        for (int j = 0; j < 16; j++) check_eq("t3_idle", get_log(j), MID);
        for (int j = 0; j < 16; j++) check_eq("t3_floor", get_log(16 + j), MID + floor7[j]);
        for (int j = 33; j < 48; j++) check_eq("t3_monotonic", get_log(j) <= get_log(j - 1), 1);
        check_eq("t3_end", get_log(47), 24'h7FFFF0);

        // Continuous in_valid: one accept per segment
        do_reset();
        acc_cyc.delete();
        bus.in_valid = 1'b1;
        bus.in_data = 24'h100000;
        repeat (6 * 256 - 8) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc_cyc.push_back(cyc);
                bus.in_data = bus.in_data + DW'($urandom_range(1, 16'h3000));
            end
        end
        bus.in_valid = 1'b0;
        acc_n = acc_cyc.size();
        check_eq("t4_accept_count", acc_n, 6);
        for (int i = 2; i < acc_cyc.size(); i++)
            check_eq("t4_accept_spacing", acc_cyc[i] - acc_cyc[i - 1], 256);

        // Underrun hold and resume
        send(24'h123456);
        wait_cycles(2 * 256 + 10);
        under_cnt = 0;
        log_q.delete();
        wait_cycles(3 * 256);
        check_eq("t5_underruns", under_cnt, 3);
        check_eq("t5_hold_ticks", log_q.size(), 48);
        foreach (log_q[i]) check_eq("t5_hold_value", log_q[i], 24'h123456);
        log_q.delete();
        send(24'h123466);
        wait_cycles(2 * 256 + 40);
        idx = first_not(24'h123456);
        for (int j = 0; j < 16; j++) check_eq("t5_resume_ramp", get_log(idx + j), 24'h123457 + j);

        // Full-scale swing, then reset mid-segment with a held sample
        do_reset();
        log_q.delete();
        send(24'h000000);
        send(24'hFFFFFF);
        send(24'h000000);
        wait_log(64, "t6_log_timeout");
        check_eq("t6_low_end", get_log(31), 24'h000000);
        for (int j = 33; j < 48; j++) check_eq("t6_rise_monotonic", get_log(j) >= get_log(j - 1), 1);
        check_eq("t6_high_end", get_log(47), 24'hFFFFFF);
        check_eq("t6_back_low", get_log(63), 24'h000000);
        send(24'h654321);
        wait_cycles(300);
        send(24'hABCDEF);
        wait_cycles(40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_rst_out_data", bus.out_data, MID);
        check_eq("t6_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        log_q.delete();
        wait_cycles(600);
        check_eq("t6_post_rst_ticks", log_q.size(), 37);
        foreach (log_q[i]) check_eq("t6_post_rst_mid", log_q[i], MID);

        // Random samples with random gaps
        do_reset();
        for (int n = 0; n < 25; n++) begin
            wait_cycles($urandom_range(0, 400));
            send(DW'($urandom_range(0, 24'hFFFFFF)));
        end
        wait_cycles(600);

        @(negedge clk);
        #1;
        check_eq("exp_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
